// File: rtl/dram_bank_cmd_fsm.sv
// dram_bank_cmd_fsm: single-bank-at-a-time DRAM command sequencer.
// Keeps an open-row table per bank, classifies each accepted request as
// EMPTY/HIT/MISS and walks ACT/RD/WR/PRE/PREA/REF with per-command wait
// counters. Refresh requests take priority over access requests in IDLE.
//
// Optional feature macro: OPEN_PAGE_EN
//   defined   - rows stay open after an access (open-page policy)
//   undefined - every access is followed by an auto-precharge of its bank
//
// Handshake: a request transfers on a cycle where req_valid && req_ready are
// both high at the rising clock edge; req_ready never depends on req_valid.
// rf_req is a level that the requester holds until the 1-cycle rf_ack pulse.
module dram_bank_cmd_fsm #(
    parameter int NUM_BANKS = 4,
    parameter int ROW_W     = 14,
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int T_CL      = 4,
    parameter int T_WR      = 5,
    parameter int T_RFC     = 8,
    localparam int BANK_W   = $clog2(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              rf_req,
    output logic              rf_ack,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ROW_W-1:0]  req_row,
    output logic              cmd_valid,
    output logic [2:0]        cmd_state,
    output logic [BANK_W-1:0] cmd_bank,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [1:0]        row_stat,
    output logic              all_row_closed,
    output logic              ram_wait,
    output logic              done,
    output logic [3:0]        dbg_state
);

`ifdef OPEN_PAGE_EN
    localparam bit OPEN_PAGE = 1'b1;
`else
    localparam bit OPEN_PAGE = 1'b0;
`endif

    // Counter must hold the largest latency value (compared before loading T-1).
    localparam int T_M1  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int T_M2  = (T_CL > T_WR) ? T_CL : T_WR;
    localparam int T_M3  = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int T_MAX = (T_M3 > T_RFC) ? T_M3 : T_RFC;
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_PREA = 3'd5;
    localparam logic [2:0] CMD_REF  = 3'd6;
    localparam logic [2:0] CMD_INIT = 3'd7;

    localparam logic [1:0] CLS_EMPTY = 2'd0;
    localparam logic [1:0] CLS_HIT   = 2'd1;
    localparam logic [1:0] CLS_MISS  = 2'd2;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_IDLE   = 4'd1,
        ST_ACT    = 4'd2,
        ST_ACT_W  = 4'd3,
        ST_RW     = 4'd4,
        ST_RW_W   = 4'd5,
        ST_PRE    = 4'd6,
        ST_PRE_W  = 4'd7,
        ST_PREA   = 4'd8,
        ST_PREA_W = 4'd9,
        ST_REF    = 4'd10,
        ST_REF_W  = 4'd11
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 lat_write;
    logic [BANK_W-1:0]    lat_bank;
    logic [ROW_W-1:0]     lat_row;
    logic [1:0]           row_stat_q;
    logic                 done_q, done_d;
    logic [NUM_BANKS-1:0] row_valid;
    logic [ROW_W-1:0]     row_addr [NUM_BANKS];
    logic [BANK_W-1:0]    cmd_bank_q;
    logic [ROW_W-1:0]     cmd_row_q;
    logic [1:0]           req_class;
    logic                 accept;
    logic [CNT_W-1:0]     rw_lat;
    logic                 cmd_valid_c;
    logic [2:0]           cmd_state_c;
    logic                 rf_ack_c;
    logic                 req_ready_c;

    assign rw_lat = lat_write ? CNT_W'(T_WR) : CNT_W'(T_CL);

    // Classify the incoming request against the open-row table.
    always_comb begin
        req_class = CLS_EMPTY;
        if (row_valid[req_bank]) begin
            req_class = (row_addr[req_bank] == req_row) ? CLS_HIT : CLS_MISS;
        end
    end

    // Next-state, counter and command decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_valid_c = 1'b0;
        cmd_state_c = CMD_NOP;
        rf_ack_c    = 1'b0;
        req_ready_c = 1'b0;
        done_d      = 1'b0;
        accept      = 1'b0;
        case (state_q)
            ST_INIT: begin
                cmd_state_c = CMD_INIT;
                if (init_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rf_req) begin
                    state_d = (|row_valid) ? ST_PREA : ST_REF;
                end else begin
                    req_ready_c = 1'b1;
                    if (req_valid) begin
                        accept = 1'b1;
                        case (req_class)
                            CLS_HIT:  state_d = ST_RW;
                            CLS_MISS: state_d = ST_PRE;
                            default:  state_d = ST_ACT;
                        endcase
                    end
                end
            end
            ST_ACT: begin
                cmd_valid_c = 1'b1;
                cmd_state_c = CMD_ACT;
                if (T_RCD == 1) begin
                    state_d = ST_RW;
                end else begin
                    cnt_d   = CNT_W'(T_RCD - 1);
                    state_d = ST_ACT_W;
                end
            end
            ST_ACT_W: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_RW;
            end
            ST_RW: begin
                cmd_valid_c = 1'b1;
                cmd_state_c = lat_write ? CMD_WR : CMD_RD;
                if (rw_lat == CNT_W'(1)) begin
                    done_d = 1'b1;
                    if (OPEN_PAGE) state_d = ST_IDLE;
                    else           state_d = ST_PRE;
                end else begin
                    cnt_d   = rw_lat - CNT_W'(1);
                    state_d = ST_RW_W;
                end
            end
            ST_RW_W: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    done_d = 1'b1;
                    if (OPEN_PAGE) state_d = ST_IDLE;
                    else           state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                cmd_valid_c = 1'b1;
                cmd_state_c = CMD_PRE;
                if (T_RP == 1) begin
                    if (OPEN_PAGE) state_d = ST_ACT;
                    else           state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_W'(T_RP - 1);
                    state_d = ST_PRE_W;
                end
            end
            ST_PRE_W: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (OPEN_PAGE) state_d = ST_ACT;
                    else           state_d = ST_IDLE;
                end
            end
            ST_PREA: begin
                cmd_valid_c = 1'b1;
                cmd_state_c = CMD_PREA;
                if (T_RP == 1) begin
                    state_d = ST_REF;
                end else begin
                    cnt_d   = CNT_W'(T_RP - 1);
                    state_d = ST_PREA_W;
                end
            end
            ST_PREA_W: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_REF;
            end
            ST_REF: begin
                cmd_valid_c = 1'b1;
                cmd_state_c = CMD_REF;
                rf_ack_c    = 1'b1;
                if (T_RFC == 1) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_W'(T_RFC - 1);
                    state_d = ST_REF_W;
                end
            end
            ST_REF_W: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State, counter, request latch and completion pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            lat_write  <= 1'b0;
            lat_bank   <= '0;
            lat_row    <= '0;
            row_stat_q <= CLS_EMPTY;
            done_q     <= 1'b0;
            cmd_bank_q <= '0;
            cmd_row_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            cmd_bank_q <= cmd_bank;
            cmd_row_q  <= cmd_row;
            if (accept) begin
                lat_write  <= req_write;
                lat_bank   <= req_bank;
                lat_row    <= req_row;
                row_stat_q <= req_class;
            end
        end
    end

    // Open-row table: ACT opens, PRE closes one bank, PREA closes all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_valid <= '0;
            for (int i = 0; i < NUM_BANKS; i++) row_addr[i] <= '0;
        end else begin
            case (state_q)
                ST_ACT: begin
                    row_valid[lat_bank] <= 1'b1;
                    row_addr[lat_bank]  <= lat_row;
                end
                ST_PRE:  row_valid[lat_bank] <= 1'b0;
                ST_PREA: row_valid <= '0;
                default: ;
            endcase
        end
    end

    // Command address outputs hold their last issued value between commands.
    assign cmd_bank       = cmd_valid_c ? lat_bank : cmd_bank_q;
    assign cmd_row        = (state_q == ST_ACT) ? lat_row : cmd_row_q;
    assign cmd_valid      = cmd_valid_c;
    assign cmd_state      = cmd_state_c;
    assign rf_ack         = rf_ack_c;
    assign req_ready      = req_ready_c;
    assign row_stat       = row_stat_q;
    assign all_row_closed = ~|row_valid;
    assign ram_wait       = (state_q != ST_IDLE) && (state_q != ST_INIT);
    assign done           = done_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_dram_bank_cmd_fsm.sv
// Bench for dram_bank_cmd_fsm: directed accesses; the driver pushes the
// expected command/done timeline into a queue, a negedge monitor pops and
// compares each command or done pulse the DUT produces.
module tb_dram_bank_cmd_fsm;

    localparam int T_RCD = 3;
    localparam int T_RP  = 3;
    localparam int T_CL  = 4;
    localparam int T_WR  = 5;
    localparam int T_RFC = 8;
    localparam int W     = 37;

`ifdef OPEN_PAGE_EN
    localparam bit OPEN = 1'b1;
`else
    localparam bit OPEN = 1'b0;
`endif

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HIT   = 2'd1;
    localparam logic [1:0] MISS  = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic        rf_req = 1'b0;
    logic        rf_ack;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_bank = '0;
    logic [13:0] req_row = '0;
    logic        cmd_valid;
    logic [2:0]  cmd_state;
    logic [1:0]  cmd_bank;
    logic [13:0] cmd_row;
    logic [1:0]  row_stat;
    logic        all_row_closed;
    logic        ram_wait;
    logic        done;
    logic [3:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_idle = 0;
    logic [W-1:0] exp_q[$];

    dram_bank_cmd_fsm #(
        .NUM_BANKS(4), .ROW_W(14), .T_RCD(T_RCD), .T_RP(T_RP),
        .T_CL(T_CL), .T_WR(T_WR), .T_RFC(T_RFC)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done), .rf_req(rf_req),
        .rf_ack(rf_ack), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_bank(req_bank), .req_row(req_row),
        .cmd_valid(cmd_valid), .cmd_state(cmd_state), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .row_stat(row_stat), .all_row_closed(all_row_closed),
        .ram_wait(ram_wait), .done(done), .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] pack(input logic d, input logic [2:0] c,
                                          input logic [1:0] b, input logic [13:0] r,
                                          input logic a, input int t);
        logic [15:0] tt;
        tt = t[15:0];
        return {d, c, b, r, a, tt};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_evt(input string name, input logic [W-1:0] act);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected actual=%0h expected=none (cycle %0d)", name, act, cyc);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, e, cyc);
            end
        end
    endtask

    // Monitor: every command cycle and every done pulse is scored.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) begin
                check_evt("cmd", pack(1'b0, cmd_state,
                    (cmd_state == 3'd5 || cmd_state == 3'd6) ? 2'd0 : cmd_bank,
                    (cmd_state == 3'd1) ? cmd_row : 14'd0, rf_ack, cyc));
            end else if (rf_ack) begin
                check_evt("rf_ack_stray", pack(1'b0, cmd_state, 2'd0, 14'd0, rf_ack, cyc));
            end
            if (done) check_evt("done", pack(1'b1, 3'd0, 2'd0, 14'd0, 1'b0, cyc));
        end
    end

    // Expected command timeline of one access accepted in cycle c0.
    task automatic push_access(input int c0, input bit wr, input logic [1:0] bank,
                               input logic [13:0] row, input logic [1:0] stat);
        int t;
        t = c0 + 1;
        if (stat == MISS) begin
            exp_q.push_back(pack(1'b0, 3'd4, bank, 14'd0, 1'b0, t));
            t += T_RP;
        end
        if (stat != HIT) begin
            exp_q.push_back(pack(1'b0, 3'd1, bank, row, 1'b0, t));
            t += T_RCD;
        end
        exp_q.push_back(pack(1'b0, wr ? 3'd3 : 3'd2, bank, 14'd0, 1'b0, t));
        t += wr ? T_WR : T_CL;
        if (OPEN) begin
            exp_q.push_back(pack(1'b1, 3'd0, 2'd0, 14'd0, 1'b0, t));
            exp_idle = t;
        end else begin
            exp_q.push_back(pack(1'b0, 3'd4, bank, 14'd0, 1'b0, t));
            exp_q.push_back(pack(1'b1, 3'd0, 2'd0, 14'd0, 1'b0, t));
            exp_idle = t + T_RP;
        end
    endtask

    // Driver: called at a negedge; waits for req_ready and issues one request.
    task automatic issue(input bit wr, input logic [1:0] bank, input logic [13:0] row,
                         input logic [1:0] stat);
        int n;
        int c0;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
        c0 = cyc;
        req_valid = 1'b1;
        req_write = wr;
        req_bank  = bank;
        req_row   = row;
        push_access(c0, wr, bank, row, stat);
        @(negedge clk);
        req_valid = 1'b0;
        chk("row_stat", {30'd0, row_stat}, {30'd0, stat});
    endtask

    // Driver: waits for the FSM to return to IDLE and checks when it did.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (ram_wait && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, cyc, exp_idle);
        if (!OPEN) chk("closed_in_idle", {31'd0, all_row_closed}, 32'd1);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        int c_rf;
        int n;

        // Test 1: reset state, INIT holds until init_done.
        @(negedge clk);
        #1;
        chk("rst_cmd_state", {29'd0, cmd_state}, 32'd7);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_all_closed", {31'd0, all_row_closed}, 32'd1);
        chk("rst_ram_wait", {31'd0, ram_wait}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_row_stat", {30'd0, row_stat}, 32'd0);
        chk("rst_cmd_row", {18'd0, cmd_row}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("init_cmd_state", {29'd0, cmd_state}, 32'd7);
        chk("init_req_ready", {31'd0, req_ready}, 32'd0);
        init_done = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_cmd_state", {29'd0, cmd_state}, 32'd0);
        chk("idle_ram_wait", {31'd0, ram_wait}, 32'd0);

        // Test 2: read to an empty bank.
        issue(1'b0, 2'd2, 14'h1A, EMPTY);
        wait_idle("t2_idle");

        // Test 3: same row again (hit under open page).
        issue(1'b0, 2'd2, 14'h1A, OPEN ? HIT : EMPTY);
        wait_idle("t3_idle");

        // Test 4: write to another row of the same bank (miss under open page).
        issue(1'b1, 2'd2, 14'h2B, OPEN ? MISS : EMPTY);
        wait_idle("t4_idle");

        // Test 5: open bank1, then refresh and request arrive together.
        issue(1'b0, 2'd1, 14'h33, EMPTY);
        wait_idle("t5_open_idle");
        chk("t5_closed_before", {31'd0, all_row_closed}, OPEN ? 32'd0 : 32'd1);
        rf_req    = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_bank  = 2'd3;
        req_row   = 14'h5;
        c_rf      = cyc;
        #1;
        chk("t5_ready_blocked", {31'd0, req_ready}, 32'd0);
        if (OPEN) begin
            exp_q.push_back(pack(1'b0, 3'd5, 2'd0, 14'd0, 1'b0, c_rf + 1));
            exp_q.push_back(pack(1'b0, 3'd6, 2'd0, 14'd0, 1'b1, c_rf + 1 + T_RP));
        end else begin
            exp_q.push_back(pack(1'b0, 3'd6, 2'd0, 14'd0, 1'b1, c_rf + 1));
        end
        n = 0;
        @(negedge clk);
        while (!rf_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_rf_ack_seen", {31'd0, rf_ack}, 32'd1);
        rf_req = 1'b0;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_ref_idle", cyc, OPEN ? c_rf + 1 + T_RP + T_RFC : c_rf + 1 + T_RFC);
        chk("t5_closed_after", {31'd0, all_row_closed}, 32'd1);
        issue(1'b1, 2'd3, 14'h5, EMPTY);
        wait_idle("t5_idle");

        // Test 6: reset in the middle of an access drops it.
        issue(1'b0, 2'd0, 14'h7, EMPTY);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_cmd_state", {29'd0, cmd_state}, 32'd7);
        chk("t6_rst_closed", {31'd0, all_row_closed}, 32'd1);
        chk("t6_rst_done", {31'd0, done}, 32'd0);
        chk("t6_rst_ram_wait", {31'd0, ram_wait}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("t6_back_idle", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 2'd0, 14'h7, EMPTY);
        wait_idle("t6_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
